// File: rtl/ccff_loader.sv
`timescale 1ns/1ps
// Configuration-chain loader: serialises a bitstream into a ccff chain, rotates
// it once to read it back, and compares CRC-16-CCITT of the written and read bits.
module ccff_loader #(
    parameter int CHAIN_LEN = 32,
    parameter int DATA_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    localparam int WB_W = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;
    localparam logic [15:0]     LAST_BIT  = 16'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0] LAST_WBIT = WB_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SHIFT  = 3'd2,
        VERIFY = 3'd3,
        CHECK  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        bit_cnt_q, bit_cnt_d;
    logic [WB_W-1:0]    wbit_q, wbit_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [15:0]        crc_in_q, crc_in_d;
    logic [15:0]        crc_out_q, crc_out_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               ready_s, clk_en_s, head_s;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Next-state, datapath and output decode
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        wbit_d    = wbit_q;
        shreg_d   = shreg_q;
        crc_in_d  = crc_in_q;
        crc_out_d = crc_out_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        ready_s   = 1'b0;
        clk_en_s  = 1'b0;
        head_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = FETCH;
                    bit_cnt_d = 16'd0;
                    wbit_d    = '0;
                    crc_in_d  = 16'hFFFF;
                    crc_out_d = 16'hFFFF;
                    pass_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                ready_s = 1'b1;
                if (s_valid) begin
                    shreg_d = s_data;
                    wbit_d  = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = FETCH;
                end
            end
            SHIFT: begin
                clk_en_s  = 1'b1;
                head_s    = shreg_q[DATA_W-1];
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 16'd1;
                wbit_d    = wbit_q + WB_W'(1);
                crc_in_d  = crc16_step(crc_in_q, shreg_q[DATA_W-1]);
                // Chain-full wins over word-empty: leftover LSBs of the last word are dropped
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = VERIFY;
                    bit_cnt_d = 16'd0;
                end else if (wbit_q == LAST_WBIT) begin
                    state_d = FETCH;
                end else begin
                    state_d = SHIFT;
                end
            end
            VERIFY: begin
                clk_en_s  = 1'b1;
                head_s    = ccff_tail;
                crc_out_d = crc16_step(crc_out_q, ccff_tail);
                bit_cnt_d = bit_cnt_q + 16'd1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = CHECK;
                    bit_cnt_d = 16'd0;
                end else begin
                    state_d = VERIFY;
                end
            end
            CHECK: begin
                pass_d  = (crc_in_q == crc_out_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort is gated combinationally so the chain sees no edge in the abort cycle
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            pass_d   = 1'b0;
            ready_s  = 1'b0;
            clk_en_s = 1'b0;
            head_s   = 1'b0;
        end else begin
            done_d = done_d;
        end
    end

    // State and datapath registers
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q   <= IDLE;
            bit_cnt_q <= 16'd0;
            wbit_q    <= '0;
            shreg_q   <= '0;
            crc_in_q  <= 16'hFFFF;
            crc_out_q <= 16'hFFFF;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            wbit_q    <= wbit_d;
            shreg_q   <= shreg_d;
            crc_in_q  <= crc_in_d;
            crc_out_q <= crc_out_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign s_ready     = ready_s & ~pReset;
    assign ccff_clk_en = clk_en_s & ~pReset;
    assign ccff_head   = head_s & clk_en_s & ~pReset;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign pass        = pass_q;

endmodule

// File: tb/tb_ccff_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for ccff_loader: two instances (32-bit and 12-bit chains),
// behavioural chain models, random bitstreams checked against a CRC/bit-list model.
module tb_ccff_loader;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    preset_s, start_s, abort_s, s_valid_s, s_ready_s;
    logic [1:0]    head_s, en_s, tail_s, busy_s, done_s, pass_s;
    logic [DW-1:0] data0_s, data1_s;

    ccff_loader #(.CHAIN_LEN(32), .DATA_W(DW)) dut0 (
        .prog_clk(clk), .pReset(preset_s[0]), .start(start_s[0]), .abort(abort_s[0]),
        .s_valid(s_valid_s[0]), .s_ready(s_ready_s[0]), .s_data(data0_s),
        .ccff_head(head_s[0]), .ccff_clk_en(en_s[0]), .ccff_tail(tail_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]));

    ccff_loader #(.CHAIN_LEN(12), .DATA_W(DW)) dut1 (
        .prog_clk(clk), .pReset(preset_s[1]), .start(start_s[1]), .abort(abort_s[1]),
        .s_valid(s_valid_s[1]), .s_ready(s_ready_s[1]), .s_data(data1_s),
        .ccff_head(head_s[1]), .ccff_clk_en(en_s[1]), .ccff_tail(tail_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]));

    // Behavioural chain: head enters at bit 0, tail is bit CHAIN_LEN-1
    logic [31:0] chain_r [2];
    int          en_cnt [2];
    int          word_cnt [2];
    int          cyc = 0;
    bit   [1:0]  stuck;
    bit   [1:0]  stop;

    assign tail_s[0] = stuck[0] ? 1'b0 : chain_r[0][31];
    assign tail_s[1] = stuck[1] ? 1'b0 : chain_r[1][11];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (en_s[k]) begin
                chain_r[k] <= {chain_r[k][30:0], head_s[k]};
                en_cnt[k]  <= en_cnt[k] + 1;
            end
            if (s_valid_s[k] && s_ready_s[k]) word_cnt[k] <= word_cnt[k] + 1;
        end
    end

    typedef struct {
        int          exp_cyc;
        bit          exp_pass;
        bit          chk_chain;
        logic [31:0] exp_chain;
        int          exp_en;
        int          exp_words;
        int          en_base;
        int          word_base;
    } sb_item_t;

    sb_item_t q0[$];
    sb_item_t q1[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int k);
        n_checks++;
        n_fail++;
        $display("FAIL %s[%0d]: got timeout expected event within cycle budget", name, k);
    endtask

    function automatic int cl_of(input int k);
        return (k == 0) ? 32 : 12;
    endfunction

    function automatic logic [31:0] mask_of(input int cl);
        return (cl >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cl) - 32'd1);
    endfunction

    // CRC over n bits of v, first bit at index n-1
    function automatic logic [15:0] crc_of(input logic [31:0] v, input int n);
        logic [15:0] crc;
        logic        fb;
        crc = 16'hFFFF;
        for (int i = n - 1; i >= 0; i--) begin
            fb  = crc[15] ^ v[i];
            crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return crc;
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int k, input sb_item_t it);
        if (k == 0) q0.push_back(it);
        else        q1.push_back(it);
    endtask

    // Monitor: compare every done pulse against the oldest expectation
    initial begin
        sb_item_t it;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (done_s[k]) begin
                    if (qsize(k) == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done[%0d]: got done=1 expected no pending load", k);
                    end else begin
                        if (k == 0) it = q0.pop_front();
                        else        it = q1.pop_front();
                        check("done_cycle", k, cyc, it.exp_cyc);
                        check("pass", k, {31'd0, pass_s[k]}, {31'd0, it.exp_pass});
                        check("en_cycles", k, en_cnt[k] - it.en_base, it.exp_en);
                        check("words", k, word_cnt[k] - it.word_base, it.exp_words);
                        if (it.chk_chain)
                            check("chain", k, chain_r[k] & mask_of(cl_of(k)), it.exp_chain);
                    end
                end
            end
        end
    end

    task automatic feed(input int k, input logic [31:0] wbits, input int nw,
                        input int gap_idx, input int gap_len);
        int t;
        for (int w = 0; w < nw; w++) begin
            t = 0;
            while (!s_ready_s[k] && !stop[k] && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (stop[k]) break;
            if (t >= 1000) begin
                fail_now("ready_timeout", k);
                break;
            end
            if (w == gap_idx) repeat (gap_len) @(negedge clk);
            if (k == 0) data0_s = wbits[31 - DW*w -: DW];
            else        data1_s = wbits[31 - DW*w -: DW];
            s_valid_s[k] = 1'b1;
            @(negedge clk);
            s_valid_s[k] = 1'b0;
        end
    endtask

    // mode 1: abort in the 20th load shift; mode 2: reset five cycles into VERIFY
    task automatic watch(input int k, input int mode, input int cl, input sb_item_t base);
        int t;
        sb_item_t it;
        if (mode == 1) begin
            t = 0;
            while (!((en_cnt[k] - base.en_base) == 19 && en_s[k]) && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 1000) fail_now("abort_window", k);
            it           = base;
            it.exp_cyc   = cyc + 1;
            it.exp_pass  = 1'b0;
            it.chk_chain = 1'b0;
            it.exp_en    = 19;
            it.exp_words = 19 / DW + 1;
            push(k, it);
            abort_s[k] = 1'b1;
            @(negedge clk);
            abort_s[k] = 1'b0;
            stop[k]    = 1'b1;
        end else if (mode == 2) begin
            t = 0;
            while (!((en_cnt[k] - base.en_base) == cl + 5 && en_s[k]) && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 1000) fail_now("verify_window", k);
            preset_s[k] = 1'b1;
            @(negedge clk);
            preset_s[k] = 1'b0;
            stop[k]     = 1'b1;
            check("midverify_reset_outputs", k,
                  {26'd0, busy_s[k], done_s[k], pass_s[k], s_ready_s[k], en_s[k], head_s[k]}, 32'd0);
        end
    endtask

    task automatic run_load(input int k, input logic [31:0] wbits, input bit stk,
                            input int gap_idx, input int gap_len, input int mode);
        int cl, nw, t;
        sb_item_t it;
        logic [31:0] loaded, readback;
        cl       = cl_of(k);
        nw       = (cl + DW - 1) / DW;
        loaded   = wbits >> (32 - cl);
        readback = stk ? 32'd0 : loaded;
        stuck[k] = stk;
        stop[k]  = 1'b0;
        @(negedge clk);
        it.en_base   = en_cnt[k];
        it.word_base = word_cnt[k];
        it.exp_cyc   = cyc + 2*cl + nw + 2 + gap_len;
        it.exp_pass  = (crc_of(loaded, cl) == crc_of(readback, cl));
        it.chk_chain = 1'b1;
        it.exp_chain = readback;
        it.exp_en    = 2*cl;
        it.exp_words = nw;
        if (mode == 0) push(k, it);
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
        fork
            feed(k, wbits, nw, gap_idx, gap_len);
            watch(k, mode, cl, it);
        join
        t = 0;
        while (qsize(k) != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            fail_now("done_timeout", k);
            if (k == 0) q0.delete();
            else        q1.delete();
        end
        if (mode == 1) begin
            repeat (5) @(negedge clk);
            check("no_shift_after_abort", k, en_cnt[k] - it.en_base, 32'd19);
        end
        if (mode == 2) repeat (40) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        preset_s  = 2'b11;
        start_s   = 2'b00;
        abort_s   = 2'b00;
        s_valid_s = 2'b00;
        data0_s   = '0;
        data1_s   = '0;
        stuck     = 2'b00;
        stop      = 2'b00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            check("reset_outputs", i,
                  {26'd0, busy_s[i], done_s[i], pass_s[i], s_ready_s[i], en_s[i], head_s[i]}, 32'd0);
        preset_s = 2'b00;
        @(negedge clk);

        // start together with abort in IDLE is ignored
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("start_abort_ignored", 0, {31'd0, busy_s[0]}, 32'd0);

        run_load(0, 32'hA53C0FF0, 1'b0, 0, 0, 0);
        run_load(0, 32'hA53C0FF0, 1'b1, 0, 0, 0);
        run_load(1, 32'h9BE70000, 1'b0, 0, 0, 0);
        run_load(0, 32'hA53C0FF0, 1'b0, 2, 10, 0);
        run_load(0, 32'h12345678, 1'b0, 0, 0, 1);
        run_load(0, 32'hA53C0FF0, 1'b0, 0, 0, 0);
        run_load(0, 32'hCAFEF00D, 1'b0, 0, 0, 2);
        run_load(0, 32'h0F1E2D3C, 1'b0, 0, 0, 0);
        run_load(1, 32'h5A5A0000, 1'b0, 0, 0, 2);
        run_load(1, 32'h3C3C0000, 1'b0, 1, 3, 0);

        for (int n = 0; n < 10; n++) begin
            k = $urandom_range(1, 0);
            run_load(k, 32'($urandom), ($urandom_range(3, 0) == 0),
                     $urandom_range((k == 0) ? 3 : 1, 0), $urandom_range(6, 0), 0);
        end

        check("scoreboard_empty", 0, qsize(0) + qsize(1), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
